// File: rtl/pito_pkg.sv
// rtl/pito_pkg.sv - shared types and defaults for the pito SoC UART transmit path
package pito_pkg;

    typedef enum logic [1:0] {
        UTX_IDLE,
        UTX_LAUNCH,
        UTX_WAIT_BUSY,
        UTX_WAIT_DONE
    } uart_tx_state_t;

    localparam int PITO_UART_TX_FIFO_DEPTH = 8;
    localparam int PITO_UART_BUSY_TIMEOUT  = 16;

endpackage

// File: rtl/pito_sync_fifo.sv
// rtl/pito_sync_fifo.sv - single-clock circular FIFO with wrap-bit pointers and occupancy
module pito_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rptr[AW-1:0]];
    assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty     = (wptr == rptr);
    assign level     = wptr - rptr;

endmodule

// File: rtl/pito_uart_tx_sched.sv
// rtl/pito_uart_tx_sched.sv - buffers core UART stores and paces them into pito_uart
module pito_uart_tx_sched
    import pito_pkg::*;
#(
    parameter int DEPTH        = PITO_UART_TX_FIFO_DEPTH,
    parameter int BUSY_TIMEOUT = PITO_UART_BUSY_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    input  logic                     uart_busy,
    output logic                     uart_wr,
    output logic [7:0]               uart_tx_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    uart_tx_state_t state;
    uart_tx_state_t state_nxt;
    logic [CW-1:0]  tmo_cnt;
    logic [7:0]     head_data;
    logic           pop;
    logic           drop;
    logic           tmo_hit;

    assign pop     = (state == UTX_LAUNCH);
    assign uart_wr = pop;
    assign drop    = wr_req && full && !pop && !flush;
    assign tmo_hit = (state == UTX_WAIT_BUSY) && !uart_busy && (tmo_cnt == CW'(1));

    pito_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (wr_req),
        .push_data (wr_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            UTX_IDLE:      if (!empty && !uart_busy) state_nxt = UTX_LAUNCH;
            UTX_LAUNCH:    state_nxt = UTX_WAIT_BUSY;
            UTX_WAIT_BUSY: begin
                if (uart_busy)    state_nxt = UTX_WAIT_DONE;
                else if (tmo_hit) state_nxt = UTX_IDLE;
            end
            UTX_WAIT_DONE: if (!uart_busy) state_nxt = UTX_IDLE;
            default:       state_nxt = UTX_IDLE;
        endcase
    end

    // Flush only touches the queue and flags; a byte already handed to the UART runs to completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= UTX_IDLE;
            tmo_cnt      <= '0;
            uart_tx_data <= 8'h00;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == UTX_LAUNCH)
                tmo_cnt <= CW'(BUSY_TIMEOUT);
            else if (state == UTX_WAIT_BUSY && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;
            if (state == UTX_IDLE && state_nxt == UTX_LAUNCH)
                uart_tx_data <= head_data;
            if (flush)     overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
            if (flush)        timeout_err <= 1'b0;
            else if (tmo_hit) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pito_uart_tx_sched.sv
// tb/tb_pito_uart_tx_sched.sv - self-checking bench for pito_uart_tx_sched
module tb_pito_uart_tx_sched;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       flush;
    logic       uart_busy;
    logic       uart_wr;
    logic [7:0] uart_tx_data;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       overflow;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       busy;
        logic       e_wr;
        logic [7:0] e_tx;
        logic [3:0] e_lvl;
        logic       e_empty;
        logic       e_full;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        int         p;
    } ent_t;

    vec_t       vecs[8];
    logic [7:0] pushq[$];
    logic [7:0] got[$];
    int         launch_at[$];
    logic       tmo_hist[$];

    pito_uart_tx_sched #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .flush        (flush),
        .uart_busy    (uart_busy),
        .uart_wr      (uart_wr),
        .uart_tx_data (uart_tx_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_req    = 1'b0;
        wr_data   = 8'h00;
        flush     = 1'b0;
        uart_busy = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " uart_wr"},     uart_wr,      1'b0);
        chk({tag, " tx_data"},     uart_tx_data, 8'h00);
        chk({tag, " full"},        full,         1'b0);
        chk({tag, " empty"},       empty,        1'b1);
        chk({tag, " level"},       level,        4'd0);
        chk({tag, " overflow"},    overflow,     1'b0);
        chk({tag, " timeout_err"}, timeout_err,  1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
    endtask

    // Simple UART model: busy rises the cycle after a launch and stays high for dur cycles.
    task automatic uart_run(input int cycles, input int dur, input int flush_at);
        int busy_end;
        busy_end = -1;
        got.delete();
        launch_at.delete();
        tmo_hist.delete();
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            uart_busy = (c <= busy_end);
            flush     = (c == flush_at);
            if (c == flush_at) begin
                wr_req  = 1'b1;
                wr_data = 8'hEE;
            end else if (pushq.size() > 0) begin
                wr_req  = 1'b1;
                wr_data = pushq.pop_front();
            end else begin
                wr_req = 1'b0;
            end
            @(negedge clk);
            tmo_hist.push_back(timeout_err);
            if (uart_wr) begin
                chk("uart_wr while busy", uart_busy, 1'b0);
                got.push_back(uart_tx_data);
                launch_at.push_back(c);
                busy_end = c + dur;
            end
        end
        idle_inputs();
    endtask

    task automatic random_test(input int cycles);
        ent_t mq[$];
        int   next_ok;
        int   busy_end;
        int   exp_c;
        int   dur;
        logic m_ovf;
        logic popped;
        logic full_pre;
        logic miss_done;
        next_ok   = 0;
        busy_end  = -1;
        m_ovf     = 1'b0;
        miss_done = 1'b0;
        exp_c     = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            uart_busy = (c <= busy_end);
            wr_req    = ($urandom_range(0, 2) == 0);
            wr_data   = 8'($urandom);
            @(negedge clk);
            chk("rnd level", level, mq.size());
            chk("rnd full", full, mq.size() == DEPTH);
            chk("rnd empty", empty, mq.size() == 0);
            chk("rnd overflow", overflow, m_ovf);
            chk("rnd timeout_err", timeout_err, 1'b0);
            popped = 1'b0;
            if (mq.size() > 0)
                exp_c = (next_ok > mq[0].p + 2) ? next_ok : mq[0].p + 2;
            if (uart_wr) begin
                chk("rnd wr while busy", uart_busy, 1'b0);
                if (mq.size() == 0) begin
                    chk("rnd spurious launch", uart_wr, 1'b0);
                end else begin
                    chk("rnd launch cycle", c, exp_c);
                    chk("rnd tx_data", uart_tx_data, mq[0].d);
                    popped = 1'b1;
                end
                dur      = $urandom_range(1, 6);
                busy_end = c + dur;
                next_ok  = c + dur + 3;
            end else if (mq.size() > 0 && c >= exp_c && !miss_done) begin
                chk("rnd missed launch", uart_wr, 1'b1);
                miss_done = 1'b1;
            end
            full_pre = (mq.size() == DEPTH);
            if (popped) void'(mq.pop_front());
            if (wr_req) begin
                if (!full_pre || popped) mq.push_back('{wr_data, c});
                else                     m_ovf = 1'b1;
            end
        end
        idle_inputs();
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 4'd1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0};

        do_reset();

        // Single byte, cycle by cycle
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            wr_req    = vecs[i].wr;
            wr_data   = vecs[i].d;
            uart_busy = vecs[i].busy;
            @(negedge clk);
            chk($sformatf("vec%0d uart_wr", i), uart_wr,      vecs[i].e_wr);
            chk($sformatf("vec%0d tx_data", i), uart_tx_data, vecs[i].e_tx);
            chk($sformatf("vec%0d level", i),   level,        vecs[i].e_lvl);
            chk($sformatf("vec%0d empty", i),   empty,        vecs[i].e_empty);
            chk($sformatf("vec%0d full", i),    full,         vecs[i].e_full);
        end
        idle_inputs();

        // Burst of 5 with a slow UART
        for (int i = 0; i < 5; i++) pushq.push_back(8'h30 + 8'(i));
        uart_run(150, 20, -1);
        chk("burst count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("burst byte%0d", i), got[i], 8'h30 + 8'(i));
        chk("burst overflow", overflow, 1'b0);

        // Overflow: UART stuck busy while 10 bytes arrive
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            uart_busy = 1'b1;
            wr_req    = 1'b1;
            wr_data   = 8'h50 + 8'(i);
            @(negedge clk);
            chk($sformatf("ovf level%0d", i), level, (i < DEPTH) ? i : DEPTH);
            chk($sformatf("ovf full%0d", i), full, i >= DEPTH);
        end
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        @(negedge clk);
        chk("ovf final level", level, DEPTH);
        chk("ovf final full", full, 1'b1);
        chk("ovf flag", overflow, 1'b1);
        uart_run(120, 3, -1);
        chk("ovf drain count", got.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < got.size(); i++)
            chk($sformatf("ovf drain byte%0d", i), got[i], 8'h50 + 8'(i));
        chk("ovf drained empty", empty, 1'b1);
        chk("ovf sticky", overflow, 1'b1);

        // Timeout: busy never rises
        pushq.push_back(8'h77);
        uart_run(40, 0, -1);
        chk("tmo launch count", got.size(), 1);
        if (got.size() > 0) begin
            chk("tmo byte", got[0], 8'h77);
            chk("tmo launch latency", launch_at[0], 2);
            if (launch_at[0] + TMO + 1 < tmo_hist.size()) begin
                chk("tmo err before expiry", tmo_hist[launch_at[0] + TMO], 1'b0);
                chk("tmo err at expiry", tmo_hist[launch_at[0] + TMO + 1], 1'b1);
            end
        end
        pushq.push_back(8'h78);
        uart_run(30, 4, -1);
        chk("tmo next count", got.size(), 1);
        if (got.size() > 0) begin
            chk("tmo next byte", got[0], 8'h78);
            chk("tmo next latency", launch_at[0], 2);
        end
        chk("tmo sticky", timeout_err, 1'b1);

        // Flush while the first byte is in WAIT_DONE, with a simultaneous push
        for (int i = 0; i < 4; i++) pushq.push_back(8'hA0 + 8'(i));
        uart_run(60, 20, 8);
        chk("flush launch count", got.size(), 1);
        if (got.size() > 0) chk("flush inflight byte", got[0], 8'hA0);
        chk("flush level", level, 4'd0);
        chk("flush empty", empty, 1'b1);
        chk("flush overflow cleared", overflow, 1'b0);
        chk("flush timeout cleared", timeout_err, 1'b0);
        chk("flush tx_data held", uart_tx_data, 8'hA0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 6; i++) pushq.push_back(8'hB0 + 8'(i));
        uart_run(7, 5, -1);
        pushq.delete();
        chk("areset pre level", level, 4'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("areset");
        @(negedge clk);
        rst_n = 1'b1;
        uart_run(20, 2, -1);
        chk("areset no launch", got.size(), 0);
        chk("areset level", level, 4'd0);

        // Randomised traffic against the queue model
        do_reset();
        random_test(1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
